pico_axil_bridge: RTL

- Responder on the PicoRV32 native memory bus (mem_valid/mem_ready handshake); initiator on AXI4-Lite toward the Ethernet MAC register space.
- Sits behind the core address mux on the peripheral leg, i.e. the range at and above ETHERNET_1_BASE_ADDR.
- Converts each native-bus transfer into one AXI4-Lite read or write, and returns a single-cycle mem_ready to the core.
- Adds a response timeout and a sticky bus-error flag.

---
 rtl/pico_axil_bridge.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/pico_axil_bridge.sv
// PicoRV32 native-bus responder to AXI4-Lite initiator bridge.
// One AXI-Lite read or write per core transfer, with timeout and sticky error.
module pico_axil_bridge #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic [2:0]  axi_awprot,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [2:0]  axi_arprot,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    output logic        bus_err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_DONE
    } state_t;

    // Counter saturates at the last allowed cycle, so it only needs that range.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_set;
    logic        tmo;
    logic        to_hit;
    logic        busy;

    // Next-state, handshake tracking, timeout and error computation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        instr_d   = instr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_set   = 1'b0;
        tmo       = 1'b0;

        busy   = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                 (state_q == S_READ)  || (state_q == S_RDATA);
        to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

        if (busy && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    cnt_d   = '0;
                    if (mem_wstrb != 4'b0000) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                awvalid_d = awvalid_q & ~axi_awready;
                wvalid_d  = wvalid_q & ~axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end else begin
                    tmo = to_hit;
                end
            end
            S_WRESP: begin
                if (axi_bvalid) begin
                    bready_d = 1'b0;
                    err_set  = (axi_bresp != 2'b00);
                    rdata_d  = '0;
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmo = to_hit;
                end
            end
            S_READ: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end else begin
                    tmo = to_hit;
                end
            end
            S_RDATA: begin
                if (axi_rvalid) begin
                    rready_d = 1'b0;
                    err_set  = (axi_rresp != 2'b00);
                    rdata_d  = err_set ? ERR_DATA : axi_rdata;
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmo = to_hit;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            err_set   = 1'b1;
            rdata_d   = (wstrb_q == 4'b0000) ? ERR_DATA : '0;
            ready_d   = 1'b1;
            state_d   = S_DONE;
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            instr_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            instr_q   <= instr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = addr_q;
    assign axi_awprot  = 3'b000;
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_bready  = bready_q;
    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = addr_q;
    assign axi_arprot  = {instr_q, 2'b00};
    assign axi_rready  = rready_q;
    assign bus_err     = err_q;

endmodule
